// File: rtl/fm_streamer_pkg.sv
// Shared types and constants for the feature-map streamer.
package fm_streamer_pkg;

    localparam int A_DSP_WIDTH = 30;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        GAP    = 2'd2
    } state_t;

    // Side length of the padded map.
    function automatic int padded_side(input int fm_size, input int padding);
        return fm_size + 2 * padding;
    endfunction

endpackage

// File: rtl/fm_streamer_if.sv
// BRAM read port plus the PE-facing sample stream of the feature-map streamer.
interface fm_streamer_if #(
    parameter int DATA_WIDTH = 30,
    parameter int ADDR_WIDTH = 16
);
    logic                         o_rd_en;
    logic [ADDR_WIDTH-1:0]        o_rd_addr;
    logic [DATA_WIDTH-1:0]        i_rd_data;
    logic signed [DATA_WIDTH-1:0] o_DataFM;
    logic                         o_en;

    modport master (
        output o_rd_en, o_rd_addr, o_DataFM, o_en,
        input  i_rd_data
    );

    modport slave (
        input  o_rd_en, o_rd_addr, o_DataFM, o_en,
        output i_rd_data
    );
endinterface

// File: rtl/fm_pad_counter.sv
// Row/column walker over the padded map; flags in-bounds pixels and the final sample.
module fm_pad_counter
    import fm_streamer_pkg::*;
#(
    parameter int FM_SIZE = 8,
    parameter int PADDING = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic advance,
    output logic in_bounds,
    output logic last
);
    localparam int S  = padded_side(FM_SIZE, PADDING);
    localparam int CW = (S > 1) ? $clog2(S) : 1;

    logic [CW-1:0] row, col;
    logic          row_in, col_in;

    assign row_in    = (int'(row) >= PADDING) && (int'(row) < PADDING + FM_SIZE);
    assign col_in    = (int'(col) >= PADDING) && (int'(col) < PADDING + FM_SIZE);
    assign in_bounds = row_in && col_in;
    assign last      = (row == CW'(S - 1)) && (col == CW'(S - 1));

    // Row is allowed to step past S-1 on the final sample; the FSM leaves STREAM there.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col == CW'(S - 1)) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end
endmodule

// File: rtl/fm_streamer.sv
// Streams a zero-padded feature map from BRAM into a convolution PE.
// Optional FM_STREAMER_PAD_VALUE_EN: adds i_pad_value, emitted on border samples instead of 0.
module fm_streamer
    import fm_streamer_pkg::*;
#(
    parameter int FM_SIZE    = 8,
    parameter int PADDING    = 1,
    parameter int DATA_WIDTH = A_DSP_WIDTH,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_start,
    input  logic [ADDR_WIDTH-1:0]        i_base_addr,
`ifdef FM_STREAMER_PAD_VALUE_EN
    input  logic signed [DATA_WIDTH-1:0] i_pad_value,
`endif
    output logic                         o_busy,
    output logic                         o_done,
    fm_streamer_if.master                bus
);
    state_t                       state, state_nxt;
    logic                         accept, in_bounds, last, rd;
    logic [ADDR_WIDTH-1:0]        addr_cnt;
    logic                         en_q, inb_q, done_q;
    logic signed [DATA_WIDTH-1:0] hold_q, pad_q, data_fm;

    assign accept = (state == IDLE) && i_start;
    assign rd     = (state == STREAM) && in_bounds;

    fm_pad_counter #(
        .FM_SIZE (FM_SIZE),
        .PADDING (PADDING)
    ) u_cnt (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .clear     (accept),
        .advance   (state == STREAM),
        .in_bounds (in_bounds),
        .last      (last)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = STREAM;
            STREAM:  if (last)    state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            addr_cnt <= '0;
            en_q     <= 1'b0;
            inb_q    <= 1'b0;
            done_q   <= 1'b0;
            hold_q   <= '0;
        end else begin
            if (accept)  addr_cnt <= i_base_addr;
            else if (rd) addr_cnt <= addr_cnt + 1'b1;
            en_q   <= (state == STREAM);
            inb_q  <= rd;
            done_q <= (state == GAP);
            if (en_q) hold_q <= data_fm;
        end
    end

`ifdef FM_STREAMER_PAD_VALUE_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)    pad_q <= '0;
        else if (accept) pad_q <= i_pad_value;
    end
`else
    assign pad_q = '0;
`endif

    // BRAM data lands in the cycle after the read, i.e. alongside o_en, so the mux is combinational.
    always_comb begin
        data_fm = hold_q;
        if (en_q) data_fm = inb_q ? $signed(bus.i_rd_data) : pad_q;
    end

    assign bus.o_rd_en   = rd;
    assign bus.o_rd_addr = addr_cnt;
    assign bus.o_en      = en_q;
    assign bus.o_DataFM  = data_fm;
    assign o_busy        = (state != IDLE);
    assign o_done        = done_q;
endmodule

// File: tb/tb_fm_streamer.sv
// Scoreboard bench: three streamer lanes (4x4 pad 1, 4x4 pad 0, 1x1 pad 0) checked against expected queues.
module tb_fm_streamer;
    localparam int NL = 3;
`ifdef FM_STREAMER_PAD_VALUE_EN
    localparam logic signed [29:0] PAD = -30'sd5;
`else
    localparam logic signed [29:0] PAD = '0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start [NL];
    logic [15:0] base  [NL];
    logic        busy  [NL];
    logic        done  [NL];
    logic        abort [NL];

    logic [29:0]        mem [256];
    logic [15:0]        aq  [NL][$];
    logic signed [29:0] dq  [NL][$];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic int fsz(input int lane);
        return (lane == 2) ? 1 : 4;
    endfunction

    function automatic int pd(input int lane);
        return (lane == 0) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < NL; g++) begin : lane
        localparam int F = (g == 2) ? 1 : 4;
        localparam int P = (g == 0) ? 1 : 0;
        localparam int S = F + 2 * P;

        fm_streamer_if #(.DATA_WIDTH(30), .ADDR_WIDTH(16)) bif ();

        fm_streamer #(
            .FM_SIZE    (F),
            .PADDING    (P),
            .DATA_WIDTH (30),
            .ADDR_WIDTH (16)
        ) dut (
            .i_clk       (clk),
            .i_rst_n     (rst_n),
            .i_start     (start[g]),
            .i_base_addr (base[g]),
`ifdef FM_STREAMER_PAD_VALUE_EN
            .i_pad_value (PAD),
`endif
            .o_busy      (busy[g]),
            .o_done      (done[g]),
            .bus         (bif)
        );

        always @(posedge clk)
            if (bif.o_rd_en) bif.i_rd_data <= mem[bif.o_rd_addr[7:0]];

        int   run     = 0;
        logic en_prev = 1'b0;

        initial begin
            repeat (2) @(negedge clk);
            chk($sformatf("reset_en[%0d]", g),     bif.o_en, 0);
            chk($sformatf("reset_busy[%0d]", g),   busy[g], 0);
            chk($sformatf("reset_done[%0d]", g),   done[g], 0);
            chk($sformatf("reset_rd_en[%0d]", g),  bif.o_rd_en, 0);
            chk($sformatf("reset_rd_addr[%0d]", g), bif.o_rd_addr, 0);
            chk($sformatf("reset_data[%0d]", g),   bif.o_DataFM, 0);
        end

        // Monitor: pops expected reads/samples and checks burst length and done timing.
        always @(negedge clk) begin
            if (bif.o_rd_en) begin
                if (aq[g].size() == 0) chk($sformatf("rd_unexpected[%0d]", g), bif.o_rd_addr, -1);
                else chk($sformatf("rd_addr[%0d]", g), bif.o_rd_addr, aq[g].pop_front());
            end
            if (bif.o_en) begin
                run++;
                if (dq[g].size() == 0) chk($sformatf("en_unexpected[%0d]", g), 1, 0);
                else chk($sformatf("data[%0d] #%0d", g, run - 1), longint'(bif.o_DataFM),
                         longint'(dq[g].pop_front()));
            end
            if (en_prev && !bif.o_en) begin
                if (abort[g]) begin
                    chk($sformatf("abort_done[%0d]", g), done[g], 0);
                    chk($sformatf("abort_busy[%0d]", g), busy[g], 0);
                    abort[g] = 1'b0;
                end else begin
                    chk($sformatf("done_after_burst[%0d]", g), done[g], 1);
                    chk($sformatf("burst_len[%0d]", g), run, S * S);
                end
                run = 0;
            end else if (done[g]) begin
                chk($sformatf("spurious_done[%0d]", g), done[g], 0);
            end
            en_prev = bif.o_en;
        end
    end

    task automatic push_frame(input int ln, input int b);
        int s, k;
        logic [15:0] a;
        s = fsz(ln) + 2 * pd(ln);
        k = 0;
        for (int r = 0; r < s; r++)
            for (int c = 0; c < s; c++) begin
                if (r >= pd(ln) && r < pd(ln) + fsz(ln) && c >= pd(ln) && c < pd(ln) + fsz(ln)) begin
                    a = 16'(b + k);
                    k++;
                    aq[ln].push_back(a);
                    dq[ln].push_back(30'(a) + 30'd1);
                end else begin
                    dq[ln].push_back(PAD);
                end
            end
    endtask

    task automatic start_frame(input int ln, input int b);
        @(posedge clk);
        #1;
        base[ln]  = 16'(b);
        start[ln] = 1'b1;
        push_frame(ln, b);
        @(posedge clk);
        #1 start[ln] = 1'b0;
    endtask

    task automatic wait_done(input int ln, input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done[ln]) return;
        end
        chk($sformatf("done_timeout[%0d]", ln), 0, 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 30'(i + 1);
        rst_n = 1'b0;
        for (int i = 0; i < NL; i++) begin
            start[i] = 1'b0;
            base[i]  = '0;
            abort[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic padded frame.
        start_frame(0, 0);
        wait_done(0, 100);

        // No padding, base 100; output holds last sample after the frame.
        start_frame(1, 100);
        wait_done(1, 100);
        @(negedge clk);
        chk("hold_last", lane[1].bif.o_DataFM, 116);

        // Start while busy is ignored; start on the done cycle is accepted.
        start_frame(0, 0);
        repeat (10) @(posedge clk);
        #1 start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        wait_done(0, 100);
        base[0]  = 16'd20;
        start[0] = 1'b1;
        push_frame(0, 20);
        @(posedge clk);
        #1 start[0] = 1'b0;
        wait_done(0, 100);

        // Reset during sample 20, then a clean frame.
        start_frame(0, 0);
        repeat (21) @(posedge clk);
        #1;
        rst_n    = 1'b0;
        abort[0] = 1'b1;
        @(posedge clk);
        #1;
        aq[0].delete();
        dq[0].delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        start_frame(0, 0);
        wait_done(0, 100);

        // One-sample frame.
        start_frame(2, 7);
        wait_done(2, 20);

        repeat (3) @(posedge clk);
        for (int i = 0; i < NL; i++) begin
            chk($sformatf("data_q_empty[%0d]", i), dq[i].size(), 0);
            chk($sformatf("addr_q_empty[%0d]", i), aq[i].size(), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
